// File: rtl/wave_acq_pkg.sv
// -----------------------------------------------------------------------------
// wave_acq_pkg
// Shared definitions for the wave acquisition scheduler:
//   - one-hot state encodings for the write and read FSMs (IDLE = bit 0), so
//     the debug state outputs are easy to decode on a logic analyser
//   - default geometry constants used as parameter defaults by the top
//   - cnt_width(): width of a counter that must reach the value n inclusive
// -----------------------------------------------------------------------------
package wave_acq_pkg;

    localparam int WAVE_SIZE_DEF  = 32;
    localparam int CLS_CYCLES_DEF = 32;

    typedef enum logic [7:0] {
        W_IDLE = 8'b0000_0001,
        W_CAPT = 8'b0000_0010,
        W_PAD  = 8'b0000_0100
    } wr_state_e;

    typedef enum logic [7:0] {
        R_IDLE   = 8'b0000_0001,
        R_STREAM = 8'b0000_0010
    } rd_state_e;

    // Bits needed to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wave_acq_scheduler_if.sv
// -----------------------------------------------------------------------------
// wave_acq_scheduler_if
// Bus between the scheduler (master) and the SDRAM wave FIFO (slave).
//   o_fifo_wr / o_fifo_wr_data : write strobe + data, driven by the master
//   i_fifo_cach_full           : write back-pressure, driven by the FIFO
//   o_fifo_rd                  : level read request for one whole wave
//   o_fifo_cls_raddr           : read-address clear, held for several cycles
//   i_fifo_rd_data/i_fifo_rd_ef: read data and its valid
//   i_fifo_rd_done             : one-cycle pulse, one-wave read complete
//
// Handshake semantics: a write transfers on every cycle o_fifo_wr is high;
// there is no ready, the master only raises o_fifo_wr after seeing
// i_fifo_cach_full low in the previous cycle. A read word transfers on every
// cycle i_fifo_rd_ef is high while o_fifo_rd is high; the master always
// accepts it (no read back-pressure). i_fifo_rd_done ends the read request.
// -----------------------------------------------------------------------------
interface wave_acq_scheduler_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  o_fifo_wr;
    logic [DATA_WIDTH-1:0] o_fifo_wr_data;
    logic                  i_fifo_cach_full;
    logic                  o_fifo_rd;
    logic                  o_fifo_cls_raddr;
    logic [DATA_WIDTH-1:0] i_fifo_rd_data;
    logic                  i_fifo_rd_ef;
    logic                  i_fifo_rd_done;

    modport master (
        output o_fifo_wr, o_fifo_wr_data, o_fifo_rd, o_fifo_cls_raddr,
        input  i_fifo_cach_full, i_fifo_rd_data, i_fifo_rd_ef, i_fifo_rd_done
    );

    modport slave (
        input  o_fifo_wr, o_fifo_wr_data, o_fifo_rd, o_fifo_cls_raddr,
        output i_fifo_cach_full, i_fifo_rd_data, i_fifo_rd_ef, i_fifo_rd_done
    );
endinterface

// File: rtl/wave_acq_wr_fsm.sv
// -----------------------------------------------------------------------------
// wave_acq_wr_fsm
// Write side of the scheduler. On an accepted trigger it captures exactly
// WAVE_SIZE ADC strobes; samples that hit cache-full are dropped and later
// replaced by zero pads so the FIFO always receives a full wave.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   arm_i, trig_i       trigger qualifier and start pulse
//   adc_valid_i/data_i  ADC sample strobe and value
//   cach_full_i         FIFO cache full
//   abort_i             clear: return to idle immediately, drop the wave
//   block_i             clear in progress: refuse new triggers
//   waves_full_i        stored-wave counter at its maximum
//   fifo_wr_o/data_o    registered FIFO write strobe and data
//   wave_done_o         one-cycle pulse: a full wave is in the FIFO
//   ovf_evt_o           one-cycle pulse: sample lost or trigger refused
//   state_o             current state (debug)
// -----------------------------------------------------------------------------
module wave_acq_wr_fsm
    import wave_acq_pkg::*;
#(
    parameter int WAVE_SIZE  = WAVE_SIZE_DEF,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  arm_i,
    input  logic                  trig_i,
    input  logic                  adc_valid_i,
    input  logic [DATA_WIDTH-1:0] adc_data_i,
    input  logic                  cach_full_i,
    input  logic                  abort_i,
    input  logic                  block_i,
    input  logic                  waves_full_i,
    output logic                  fifo_wr_o,
    output logic [DATA_WIDTH-1:0] fifo_wr_data_o,
    output logic                  wave_done_o,
    output logic                  ovf_evt_o,
    output wr_state_e             state_o
);

    localparam int SC_W = $clog2(WAVE_SIZE);
    localparam int WC_W = cnt_width(WAVE_SIZE);

    wr_state_e             state_q, state_d;
    logic [SC_W-1:0]       sc_q, sc_d;      // ADC strobes seen this wave
    logic [WC_W-1:0]       wc_q, wc_d;      // FIFO writes issued this wave
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic trig_armed;
    assign trig_armed = trig_i & arm_i;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= W_IDLE;
            sc_q    <= '0;
            wc_q    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            wc_q    <= wc_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sc_d        = sc_q;
        wc_d        = wc_q;
        wr_d        = 1'b0;
        wdata_d     = wdata_q;
        wave_done_o = 1'b0;
        ovf_evt_o   = 1'b0;

        if (abort_i) begin
            state_d = W_IDLE;
            sc_d    = '0;
            wc_d    = '0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (trig_armed) begin
                        if (!waves_full_i && !block_i) begin
                            state_d = W_CAPT;
                            sc_d    = '0;
                            wc_d    = '0;
                        end else begin
                            ovf_evt_o = 1'b1;
                        end
                    end
                end

                W_CAPT: begin
                    if (trig_armed) ovf_evt_o = 1'b1;
                    if (adc_valid_i) begin
                        sc_d = sc_q + 1'b1;
                        if (cach_full_i) begin
                            ovf_evt_o = 1'b1;
                        end else begin
                            wr_d    = 1'b1;
                            wdata_d = adc_data_i;
                            wc_d    = wc_q + 1'b1;
                        end
                        // The last strobe ends capture whether or not it was written.
                        if (sc_q == SC_W'(WAVE_SIZE - 1)) state_d = W_PAD;
                    end
                end

                W_PAD: begin
                    if (trig_armed) ovf_evt_o = 1'b1;
                    // wc_q already includes the last capture write, so a loss-free
                    // wave leaves this state in its first cycle.
                    if (wc_q == WC_W'(WAVE_SIZE)) begin
                        wave_done_o = 1'b1;
                        state_d     = W_IDLE;
                    end else if (!cach_full_i) begin
                        wr_d    = 1'b1;
                        wdata_d = '0;
                        wc_d    = wc_q + 1'b1;
                    end
                end

                default: state_d = W_IDLE;
            endcase
        end
    end

    assign fifo_wr_o      = wr_q;
    assign fifo_wr_data_o = wdata_q;
    assign state_o        = state_q;

endmodule

// File: rtl/wave_acq_scheduler.sv
// -----------------------------------------------------------------------------
// wave_acq_scheduler
// Sequences the SDRAM wave FIFO for one ultrasonic channel: triggers capture
// of fixed-size waves into the FIFO (wave_acq_wr_fsm), host requests read
// one wave back out as a framed stream, a counter tracks stored waves, and
// i_clear discards everything and pulses the FIFO read-address clear.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_arm, i_trig            trigger qualifier and wave start pulse
//   i_adc_valid, i_adc_data  ADC sample strobe and value
//   i_host_req               level: request next stored wave
//   i_clear                  pulse: discard all stored waves
//   fifo                     FIFO bus (master side)
//   o_out_data/valid/sof/eof host stream, no back-pressure
//   o_waves                  stored-wave count
//   o_busy                   either FSM active or clear in progress
//   o_overflow, o_rd_err     sticky error flags, cleared by i_clear only
//   o_wr_state, o_rd_state   FSM states (debug)
// -----------------------------------------------------------------------------
module wave_acq_scheduler
    import wave_acq_pkg::*;
#(
    parameter int WAVE_SIZE  = WAVE_SIZE_DEF,
    parameter int DATA_WIDTH = 16,
    parameter int WCNT_WIDTH = 5,
    parameter int RD_TIMEOUT = 1024,
    parameter int CLS_CYCLES = CLS_CYCLES_DEF
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_arm,
    input  logic                            i_trig,
    input  logic                            i_adc_valid,
    input  logic [DATA_WIDTH-1:0]           i_adc_data,
    input  logic                            i_host_req,
    input  logic                            i_clear,
    wave_acq_scheduler_if.master            fifo,
    output logic [DATA_WIDTH-1:0]           o_out_data,
    output logic                            o_out_valid,
    output logic                            o_out_sof,
    output logic                            o_out_eof,
    output logic [WCNT_WIDTH-1:0]           o_waves,
    output logic                            o_busy,
    output logic                            o_overflow,
    output logic                            o_rd_err,
    output logic [7:0]                      o_wr_state,
    output logic [7:0]                      o_rd_state
);

    localparam int RC_W  = cnt_width(WAVE_SIZE);
    localparam int TM_W  = cnt_width(RD_TIMEOUT);
    localparam int CLS_W = cnt_width(CLS_CYCLES);

    // ---------------------------------------------------------------- state
    rd_state_e             rd_state_q, rd_state_d;
    logic [RC_W-1:0]       rc_q, rc_d;          // words forwarded this read
    logic [TM_W-1:0]       timer_q, timer_d;    // cycles spent in R_STREAM
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_sof_q, out_sof_d;
    logic                  out_eof_q, out_eof_d;
    logic [WCNT_WIDTH-1:0] waves_q, waves_d;
    logic [CLS_W-1:0]      cls_cnt_q, cls_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  rd_err_q, rd_err_d;

    logic                  clearing;            // read-address clear still running
    logic                  waves_full;
    logic                  wave_done;
    logic                  ovf_evt;
    logic                  rd_dec;
    logic                  rd_err_evt;
    wr_state_e             wr_state;

    assign clearing   = (cls_cnt_q != '0);
    assign waves_full = &waves_q;

    // ----------------------------------------------------------- write side
    wave_acq_wr_fsm #(
        .WAVE_SIZE  (WAVE_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_fsm (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .arm_i          (i_arm),
        .trig_i         (i_trig),
        .adc_valid_i    (i_adc_valid),
        .adc_data_i     (i_adc_data),
        .cach_full_i    (fifo.i_fifo_cach_full),
        .abort_i        (i_clear),
        .block_i        (clearing),
        .waves_full_i   (waves_full),
        .fifo_wr_o      (fifo.o_fifo_wr),
        .fifo_wr_data_o (fifo.o_fifo_wr_data),
        .wave_done_o    (wave_done),
        .ovf_evt_o      (ovf_evt),
        .state_o        (wr_state)
    );

    // ------------------------------------------------------------ registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_state_q  <= R_IDLE;
            rc_q        <= '0;
            timer_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            waves_q     <= '0;
            cls_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            rc_q        <= rc_d;
            timer_q     <= timer_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            waves_q     <= waves_d;
            cls_cnt_q   <= cls_cnt_d;
            ovf_q       <= ovf_d;
            rd_err_q    <= rd_err_d;
        end
    end

    // ------------------------------------------------- read FSM next state
    always_comb begin
        rd_state_d  = rd_state_q;
        rc_d        = rc_q;
        timer_d     = timer_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        rd_dec      = 1'b0;
        rd_err_evt  = 1'b0;

        if (i_clear) begin
            rd_state_d = R_IDLE;
            rc_d       = '0;
            timer_d    = '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (i_host_req && (waves_q != '0) && !clearing) begin
                        rd_state_d = R_STREAM;
                        rc_d       = '0;
                        timer_d    = '0;
                    end
                end

                R_STREAM: begin
                    timer_d = timer_q + 1'b1;
                    if (fifo.i_fifo_rd_ef) begin
                        if (rc_q != RC_W'(WAVE_SIZE)) begin
                            out_data_d  = fifo.i_fifo_rd_data;
                            out_valid_d = 1'b1;
                            out_sof_d   = (rc_q == '0);
                            out_eof_d   = (rc_q == RC_W'(WAVE_SIZE - 1));
                            rc_d        = rc_q + 1'b1;
                        end else begin
                            // Surplus word beyond one wave: drop and flag.
                            rd_err_evt = 1'b1;
                        end
                    end
                    // Done wins over a timeout landing in the same cycle; rc_d
                    // counts a word arriving together with done.
                    if (fifo.i_fifo_rd_done) begin
                        rd_state_d = R_IDLE;
                        rd_dec     = 1'b1;
                        if (rc_d != RC_W'(WAVE_SIZE)) rd_err_evt = 1'b1;
                    end else if (timer_q == TM_W'(RD_TIMEOUT - 1)) begin
                        rd_state_d = R_IDLE;
                        rd_err_evt = 1'b1;
                    end
                end

                default: rd_state_d = R_IDLE;
            endcase
        end
    end

    // ------------------------------------- wave count, clear, sticky flags
    always_comb begin
        waves_d   = waves_q;
        cls_cnt_d = cls_cnt_q;
        ovf_d     = ovf_q | ovf_evt;
        rd_err_d  = rd_err_q | rd_err_evt;

        if (i_clear) begin
            waves_d   = '0;
            cls_cnt_d = CLS_W'(CLS_CYCLES);
            ovf_d     = 1'b0;
            rd_err_d  = 1'b0;
        end else begin
            // Store and retire in the same cycle cancel out.
            case ({wave_done, rd_dec})
                2'b10:   waves_d = waves_q + 1'b1;
                2'b01:   waves_d = waves_q - 1'b1;
                default: waves_d = waves_q;
            endcase
            if (clearing) cls_cnt_d = cls_cnt_q - 1'b1;
        end
    end

    // -------------------------------------------------------------- outputs
    assign fifo.o_fifo_rd        = (rd_state_q == R_STREAM);
    assign fifo.o_fifo_cls_raddr = clearing;

    assign o_out_data  = out_data_q;
    assign o_out_valid = out_valid_q;
    assign o_out_sof   = out_sof_q;
    assign o_out_eof   = out_eof_q;
    assign o_waves     = waves_q;
    assign o_busy      = (wr_state != W_IDLE) | (rd_state_q != R_IDLE) | clearing;
    assign o_overflow  = ovf_q;
    assign o_rd_err    = rd_err_q;
    assign o_wr_state  = wr_state;
    assign o_rd_state  = rd_state_q;

endmodule
